ni_crc_multi_channel: RTL and testbench
=======================================

# ni_crc_multi_channel

Parametrised multi-channel CRC-32 engine for the network interface, successor to the fixed 32-bit multi-channel CRC generator. It keeps one running CRC per channel, accepts packet beats of configurable width with start-of-packet and end-of-packet framing and a partial last beat, and returns a finished, post-XORed CRC per packet through a valid/ready result port. It sits between the NI packet framer or de-framer and the per-channel DMA/FIFO logic.

## Interface
- CHANNEL, 4: number of independent CRC contexts (≥1); CHw = log2(CHANNEL), minimum 1.
- DATA_W, 32: beat width in bits; one of 8, 16, 32, 64. BYTES = DATA_W/8; BEw = log2(BYTES+1).
- CRC_INIT, 32'hFFFFFFFF: value loaded into a context on sop.
- CRC_XOROUT, 32'hFFFFFFFF: XOR applied to the final state to form the result.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_ch  in  CHw  channel of the beat.
- in_sop  in  1  first beat of a packet.
- in_eop  in  1  last beat of a packet.
- in_nbytes  in  BEw  valid bytes on an eop beat (1..BYTES), from lane 0 upward; ignored on non-eop beats, which are always full.
- in_data  in  DATA_W  beat data; byte lane k = in_data[8k+7:8k].
- res_valid  out  1  result held.
- res_ready  in  1  result consumed when res_valid & res_ready.
- res_ch  out  CHw  channel of the result.
- res_crc  out  32  final CRC = state ^ CRC_XOROUT.
- err_pulse  out  1  one-cycle framing-error flag.
- Macro NI_CRC_CHECK_EN adds: in_crc_ref (in, 32) and res_ok (out, 1). See Configuration.

## Operation
- Polynomial 0x04C11DB7, non-reflected. Update equations are identical to the team's existing 32-bit combinational CRC step for 4 bytes. An n-byte step is n successive single-byte steps, lane 0 first.
- Each channel has a 32-bit state and a 1-bit flag, `active`. Reset clears both to 0.
- Accepted beat on channel c, with base = CRC_INIT if in_sop, else state[c]:
  - Non-active, no sop: beat dropped, state unchanged, err_pulse=1.
  - sop while active: restart from CRC_INIT, err_pulse=1.
  - sop&eop: a single-beat packet; nbytes applies.
  - Otherwise: state[c] ← step(base, data, nbytes or BYTES); active[c] ← in_sop|active[c], cleared on eop.
- On eop the stepped value goes directly to the result register: res_ch=c, res_crc=stepped^CRC_XOROUT, res_valid=1. state[c] is left holding the stepped value.
- in_nbytes of 0 or >BYTES on eop is treated as BYTES and raises err_pulse.
- Only the addressed channel changes; other contexts are untouched.

## Timing
- Values after reset: in_ready=1, res_valid=0, res_ch=0, res_crc=0, err_pulse=0, res_ok=0.
- in_ready = !res_valid | res_ready, combinational. This backpressures every beat, not only eop beats.
- Latency: the result is visible the cycle after the eop beat is accepted. Back-to-back eop beats give one result per cycle while res_ready=1.
- Consecutive beats on the same channel have no bubble; the state is written in the accepting cycle.
- A result held with res_ready=0 stays stable, with all fields constant.
- Reset asserted mid-packet: all contexts become idle. The next beat without sop is dropped with an error.
- err_pulse is high for the single cycle after the offending beat.

## Configuration
- NI_CRC_CHECK_EN defined: in_crc_ref is sampled with each eop beat. res_ok = (res_crc == in_crc_ref), registered alongside res_crc. This mode is used on the receive side.
- Not defined: the in_crc_ref and res_ok ports and their logic are absent. Generate-only behaviour is unchanged.

## Structure
- Shared package ni_crc_pkg holds: the polynomial constant, the default INIT/XOROUT values, a byte-step function, and the log2 function.
- Sub-module ni_crc32_step: combinational, parameter BYTES, inputs crc_in/data/nbytes, output crc_out. It consists of a chain of byte steps with an nbytes mux.
- The top level holds the context array, active flags, result register, and error logic.

## Test plan
- Reset then idle: all outputs at their reset values. With CRC_INIT=0 and CRC_XOROUT=0, a single sop&eop beat of data 0 on ch 2 gives res_crc=0 and res_ch=2 one cycle later.
- DATA_W=32, full beats, INIT=0, XOROUT=0: the sequence 0x00000001, 0x12345678 gives res_crc equal to the existing 32-bit combinational step applied twice.
- Interleave ch0 and ch1 beats of two packets: each res_crc equals its single-channel run.
- Last beat with nbytes=1 versus the same packet sent through DATA_W=8: the two res_crc values are identical.
- res_ready=0 for 5 cycles with a result held: in_ready=0, the result is stable, and no beat is accepted. Releasing it gives the next result the following cycle.
- Framing errors: a beat on an idle channel without sop, and a sop on an active channel, each give err_pulse=1 for one cycle. With NI_CRC_CHECK_EN, in_crc_ref equal to the expected CRC gives res_ok=1; flipping one bit gives res_ok=0.

Source files
------------

// File: rtl/ni_crc_pkg.sv
// Shared CRC-32 definitions: polynomial, default init/xorout,
// MSB-first byte step, and a log2 helper for port widths.
package ni_crc_pkg;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT_DEF = 32'hFFFFFFFF;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0] d
  );
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int i = 0; i < 8; i++) begin
      r = r[31] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  // Ceiling log2 with a floor of 1 so widths never collapse.
  function automatic int crc_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ni_crc_multi_channel_if.sv
// Beat input, result output and error flag of the CRC engine.
// master: packet source / result sink; slave: the engine.
interface ni_crc_multi_channel_if #(
  parameter int CHW = 2,
  parameter int DATA_W = 32,
  parameter int BEW = 3
);
  logic in_valid;
  logic in_ready;
  logic [CHW-1:0] in_ch;
  logic in_sop;
  logic in_eop;
  logic [BEW-1:0] in_nbytes;
  logic [DATA_W-1:0] in_data;
  logic res_valid;
  logic res_ready;
  logic [CHW-1:0] res_ch;
  logic [31:0] res_crc;
  logic err_pulse;
`ifdef NI_CRC_CHECK_EN
  logic [31:0] in_crc_ref;
  logic res_ok;

  modport master (
    output in_valid, in_ch, in_sop, in_eop,
    output in_nbytes, in_data, res_ready,
    output in_crc_ref,
    input in_ready, res_valid, res_ch,
    input res_crc, err_pulse, res_ok
  );

  modport slave (
    input in_valid, in_ch, in_sop, in_eop,
    input in_nbytes, in_data, res_ready,
    input in_crc_ref,
    output in_ready, res_valid, res_ch,
    output res_crc, err_pulse, res_ok
  );
`else
  modport master (
    output in_valid, in_ch, in_sop, in_eop,
    output in_nbytes, in_data, res_ready,
    input in_ready, res_valid, res_ch,
    input res_crc, err_pulse
  );

  modport slave (
    input in_valid, in_ch, in_sop, in_eop,
    input in_nbytes, in_data, res_ready,
    output in_ready, res_valid, res_ch,
    output res_crc, err_pulse
  );
`endif
endinterface

// File: rtl/ni_crc32_step.sv
// Combinational CRC-32 over 1..BYTES bytes, lane 0 first.
// crc_in/data/nbytes in, crc_out out; nbytes must be 1..BYTES.
module ni_crc32_step
  import ni_crc_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int BEW = 3
) (
  input  logic [31:0] crc_in,
  input  logic [8*BYTES-1:0] data,
  input  logic [BEW-1:0] nbytes,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    crc_out = crc_in;
    for (int k = 0; k < BYTES; k++) begin
      c = crc_byte(c, data[8*k +: 8]);
      if (nbytes == BEW'(k + 1)) crc_out = c;
    end
  end

endmodule

// File: rtl/ni_crc_multi_channel.sv
// Multi-channel CRC-32 engine: per-channel context, framed beats,
// registered result; clk, reset (async low), bus slave modport.
// NI_CRC_CHECK_EN adds in_crc_ref compare and res_ok.
module ni_crc_multi_channel
  import ni_crc_pkg::*;
#(
  parameter int CHANNEL = 4,
  parameter int DATA_W = 32,
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
  input logic clk,
  input logic reset,
  ni_crc_multi_channel_if.slave bus
);

  localparam int BYTES = DATA_W / 8;
  localparam int CHW = crc_log2(CHANNEL);
  localparam int BEW = crc_log2(BYTES + 1);

  logic [31:0] state [CHANNEL];
  logic [CHANNEL-1:0] active;
  logic res_valid;
  logic [CHW-1:0] res_ch;
  logic [31:0] res_crc;
  logic err;

  logic fire, take, drop, nb_bad, err_next, act_c;
  logic [BEW-1:0] nb_eff;
  logic [31:0] base, stepped, final_crc;

  assign bus.in_ready = !res_valid | bus.res_ready;
  assign fire = bus.in_valid & bus.in_ready;
  assign act_c = active[bus.in_ch];
  assign drop = !bus.in_sop & !act_c;
  assign take = fire & !drop;

  assign nb_bad = bus.in_eop &
    ((bus.in_nbytes == '0) |
     (bus.in_nbytes > BEW'(BYTES)));
  assign nb_eff = (!bus.in_eop | nb_bad) ?
    BEW'(BYTES) : bus.in_nbytes;

  assign err_next = fire &
    (drop | (bus.in_sop & act_c) | nb_bad);

  assign base = bus.in_sop ? CRC_INIT : state[bus.in_ch];
  assign final_crc = stepped ^ CRC_XOROUT;

  ni_crc32_step #(
    .BYTES(BYTES),
    .BEW(BEW)
  ) u_step (
    .crc_in(base),
    .data(bus.in_data),
    .nbytes(nb_eff),
    .crc_out(stepped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNEL; i++) state[i] <= '0;
      active <= '0;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_crc <= '0;
      err <= 1'b0;
    end else begin
      if (take) begin
        state[bus.in_ch] <= stepped;
        active[bus.in_ch] <= !bus.in_eop;
      end
      if (take & bus.in_eop) begin
        res_valid <= 1'b1;
        res_ch <= bus.in_ch;
        res_crc <= final_crc;
      end else if (bus.res_ready) begin
        res_valid <= 1'b0;
      end
      err <= err_next;
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_ch = res_ch;
  assign bus.res_crc = res_crc;
  assign bus.err_pulse = err;

`ifdef NI_CRC_CHECK_EN
  logic res_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_ok <= 1'b0;
    end else if (take & bus.in_eop) begin
      res_ok <= (final_crc == bus.in_crc_ref);
    end
  end

  assign bus.res_ok = res_ok;
`endif

endmodule

// File: tb/tb_ni_crc_multi_channel.sv
// Self-checking bench for ni_crc_multi_channel: vector table on a
// zero-init 32-bit engine plus directed multi-cycle sequences.
module tb_ni_crc_multi_channel;

  logic clk;
  logic reset;
  int errors;
  int checks;

  ni_crc_multi_channel_if #(.CHW(2), .DATA_W(32), .BEW(3)) bz();
  ni_crc_multi_channel_if #(.CHW(2), .DATA_W(32), .BEW(3)) bd();
  ni_crc_multi_channel_if #(.CHW(2), .DATA_W(8), .BEW(1)) bb();

  ni_crc_multi_channel #(
    .CHANNEL(4), .DATA_W(32),
    .CRC_INIT(32'h0), .CRC_XOROUT(32'h0)
  ) u_z (.clk(clk), .reset(reset), .bus(bz));

  ni_crc_multi_channel #(
    .CHANNEL(4), .DATA_W(32)
  ) u_d (.clk(clk), .reset(reset), .bus(bd));

  ni_crc_multi_channel #(
    .CHANNEL(4), .DATA_W(8)
  ) u_b (.clk(clk), .reset(reset), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] ch;
    logic sop;
    logic eop;
    logic [2:0] nb;
    logic [31:0] data;
    logic ev;
    logic [1:0] ech;
    logic [31:0] ecrc;
    logic eerr;
  } vec_t;

  vec_t tv [14];

  // Bit-serial reference: one data bit per shift, MSB of each byte
  // first, lane 0 first.
  function automatic logic [31:0] m_step(
    input logic [31:0] c,
    input logic [31:0] d,
    input int n
  );
    logic fb;
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[31] ^ d[8*k+b];
        c = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    return c;
  endfunction

  function automatic vec_t mk(
    input logic [1:0] ch, input logic sop,
    input logic eop, input logic [2:0] nb,
    input logic [31:0] data, input logic ev,
    input logic [31:0] ecrc, input logic eerr
  );
    vec_t v;
    v.ch = ch; v.sop = sop; v.eop = eop;
    v.nb = nb; v.data = data; v.ev = ev;
    v.ech = ch; v.ecrc = ecrc; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
        name, act, exp);
    end
  endtask

  task automatic z_beat(
    input logic [1:0] ch, input logic sop,
    input logic eop, input logic [2:0] nb,
    input logic [31:0] data
  );
    bz.in_valid = 1'b1;
    bz.in_ch = ch;
    bz.in_sop = sop;
    bz.in_eop = eop;
    bz.in_nbytes = nb;
    bz.in_data = data;
    @(posedge clk);
    #1;
    bz.in_valid = 1'b0;
  endtask

  logic [7:0] s [9];
  logic [31:0] crc_d, crc_b, held, e;

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bz.in_valid = 0; bz.in_ch = 0; bz.in_sop = 0;
    bz.in_eop = 0; bz.in_nbytes = 0; bz.in_data = 0;
    bz.res_ready = 1;
    bd.in_valid = 0; bd.in_ch = 0; bd.in_sop = 0;
    bd.in_eop = 0; bd.in_nbytes = 0; bd.in_data = 0;
    bd.res_ready = 1;
    bb.in_valid = 0; bb.in_ch = 0; bb.in_sop = 0;
    bb.in_eop = 0; bb.in_nbytes = 0; bb.in_data = 0;
    bb.res_ready = 1;
`ifdef NI_CRC_CHECK_EN
    bz.in_crc_ref = 0;
    bd.in_crc_ref = 0;
    bb.in_crc_ref = 0;
`endif

    tv[0] = mk(2, 1, 1, 4, 32'h0, 1, 32'h0, 0);
    tv[1] = mk(1, 1, 1, 1, 32'h1, 1, 32'h04C11DB7, 0);
    tv[2] = mk(3, 1, 1, 2, 32'h1, 1, 32'hD219C1DC, 0);
    tv[3] = mk(0, 1, 0, 0, 32'h1, 0, 32'h0, 0);
    tv[4] = mk(0, 0, 1, 4, 32'h12345678, 1,
      m_step(m_step(0, 32'h1, 4), 32'h12345678, 4), 0);
    tv[5] = mk(1, 0, 0, 4, 32'h5, 0, 32'h0, 1);
    tv[6] = mk(2, 1, 0, 4, 32'hA5A5F00F, 0, 32'h0, 0);
    tv[7] = mk(1, 1, 0, 4, 32'hDEADBEEF, 0, 32'h0, 0);
    tv[8] = mk(2, 0, 1, 4, 32'h0BADCAFE, 1,
      m_step(m_step(0, 32'hA5A5F00F, 4),
        32'h0BADCAFE, 4), 0);
    tv[9] = mk(1, 0, 1, 3, 32'hFF112233, 1,
      m_step(m_step(0, 32'hDEADBEEF, 4),
        32'h00112233, 3), 0);
    tv[10] = mk(3, 1, 0, 4, 32'h11111111, 0, 32'h0, 0);
    tv[11] = mk(3, 1, 0, 4, 32'h80000001, 0, 32'h0, 1);
    tv[12] = mk(3, 0, 1, 0, 32'h76543210, 1,
      m_step(m_step(0, 32'h80000001, 4),
        32'h76543210, 4), 1);
    tv[13] = mk(0, 1, 1, 7, 32'hCAFEF00D, 1,
      m_step(0, 32'hCAFEF00D, 4), 1);

    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
          8'h36, 8'h37, 8'h38, 8'h39};

    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bz.in_ready), 32'd1);
    chk("rst_res_valid", 32'(bz.res_valid), 32'd0);
    chk("rst_res_ch", 32'(bz.res_ch), 32'd0);
    chk("rst_res_crc", bz.res_crc, 32'h0);
    chk("rst_err", 32'(bz.err_pulse), 32'd0);
    chk("rst_d_crc", bd.res_crc, 32'h0);
`ifdef NI_CRC_CHECK_EN
    chk("rst_res_ok", 32'(bz.res_ok), 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_res_valid", 32'(bz.res_valid), 32'd0);

    for (int i = 0; i < 14; i++) begin
      bz.in_valid = 1'b1;
      bz.in_ch = tv[i].ch;
      bz.in_sop = tv[i].sop;
      bz.in_eop = tv[i].eop;
      bz.in_nbytes = tv[i].nb;
      bz.in_data = tv[i].data;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i),
        32'(bz.res_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("v%0d_ch", i),
          32'(bz.res_ch), 32'(tv[i].ech));
        chk($sformatf("v%0d_crc", i),
          bz.res_crc, tv[i].ecrc);
      end
      chk($sformatf("v%0d_err", i),
        32'(bz.err_pulse), 32'(tv[i].eerr));
    end
    bz.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(bz.err_pulse), 32'd0);

    // Backpressure: held result blocks a pending mid-packet eop.
    z_beat(0, 1, 0, 4, 32'h01020304);
    bz.res_ready = 1'b0;
    z_beat(1, 1, 1, 4, 32'h55AA55AA);
    held = m_step(0, 32'h55AA55AA, 4);
    chk("bp_res_crc", bz.res_crc, held);
    bz.in_valid = 1'b1;
    bz.in_ch = 0; bz.in_sop = 0; bz.in_eop = 1;
    bz.in_nbytes = 4; bz.in_data = 32'h0F0E0D0C;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bz.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bz.res_valid), 32'd1);
      chk("bp_ch", 32'(bz.res_ch), 32'd1);
      chk("bp_crc", bz.res_crc, held);
      chk("bp_err", 32'(bz.err_pulse), 32'd0);
    end
    bz.res_ready = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bz.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bz.in_valid = 1'b0;
    chk("rel_valid", 32'(bz.res_valid), 32'd1);
    chk("rel_ch", 32'(bz.res_ch), 32'd0);
    chk("rel_crc", bz.res_crc,
      m_step(m_step(0, 32'h01020304, 4),
        32'h0F0E0D0C, 4));
    chk("rel_err", 32'(bz.err_pulse), 32'd0);
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(bz.res_valid), 32'd0);

    // Reset in the middle of a packet idles the context.
    z_beat(2, 1, 0, 4, 32'h12121212);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bz.res_valid), 32'd0);
    chk("mid_rst_crc", bz.res_crc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    z_beat(2, 0, 1, 4, 32'h34343434);
    chk("post_rst_err", 32'(bz.err_pulse), 32'd1);
    chk("post_rst_valid", 32'(bz.res_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_err_clr", 32'(bz.err_pulse), 32'd0);

`ifdef NI_CRC_CHECK_EN
    e = m_step(0, 32'h9ABCDEF0, 4);
    bz.in_crc_ref = e;
    z_beat(0, 1, 1, 4, 32'h9ABCDEF0);
    chk("ok_match", 32'(bz.res_ok), 32'd1);
    bz.in_crc_ref = e ^ 32'h00000100;
    z_beat(0, 1, 1, 4, 32'h9ABCDEF0);
    chk("ok_flip", 32'(bz.res_ok), 32'd0);
    chk("ok_flip_crc", bz.res_crc, e);
`endif

    // "123456789" on default init/xorout: 32-bit beats with a
    // one-byte tail, then the same bytes on the 8-bit engine.
    bd.in_valid = 1; bd.in_ch = 3; bd.in_nbytes = 4;
    bd.in_sop = 1; bd.in_eop = 0;
    bd.in_data = 32'h34333231;
    @(posedge clk);
    #1;
    bd.in_sop = 0;
    bd.in_data = 32'h38373635;
    @(posedge clk);
    #1;
    bd.in_eop = 1; bd.in_nbytes = 1;
    bd.in_data = 32'hEEEEEE39;
    @(posedge clk);
    #1;
    bd.in_valid = 0;
    chk("d_valid", 32'(bd.res_valid), 32'd1);
    chk("d_ch", 32'(bd.res_ch), 32'd3);
    chk("d_crc", bd.res_crc, 32'hFC891918);
    chk("d_err", 32'(bd.err_pulse), 32'd0);
    crc_d = bd.res_crc;

    for (int i = 0; i < 9; i++) begin
      bb.in_valid = 1;
      bb.in_ch = 1;
      bb.in_sop = (i == 0);
      bb.in_eop = (i == 8);
      bb.in_nbytes = 1;
      bb.in_data = s[i];
      @(posedge clk);
      #1;
    end
    bb.in_valid = 0;
    chk("b_valid", 32'(bb.res_valid), 32'd1);
    chk("b_crc", bb.res_crc, 32'hFC891918);
    crc_b = bb.res_crc;
    chk("d_vs_b", crc_d, crc_b);

    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
